// File: rtl/coffee_pkg.sv
// Shared encodings for the coffee machine stimulus sequencer.
package coffee_pkg;

   typedef enum logic [2:0] {
      CENT5  = 3'd0,
      CENT10 = 3'd1,
      CENT25 = 3'd2,
      CENT50 = 3'd3,
      REAL1  = 3'd4,
      REAL2  = 3'd5,
      REAL5  = 3'd6,
      REAL10 = 3'd7
   } coin_e;

   typedef enum logic [1:0] {
      CAFE         = 2'd0,
      CAPUCCINO    = 2'd1,
      CAFE_LONGO   = 2'd2,
      ACHOCOLATADO = 2'd3
   } product_e;

   // Script entry kind bit (entry MSB)
   localparam logic KIND_COIN = 1'b0;
   localparam logic KIND_SEL  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST_DUT,
      ST_FETCH,
      ST_DRIVE,
      ST_GAP,
      ST_DONE
   } seq_state_e;

   // Coin value in centavos
   function automatic logic [15:0] coin_value(input logic [2:0] code);
      logic [15:0] v;
      case (coin_e'(code))
         CENT5:   v = 16'd5;
         CENT10:  v = 16'd10;
         CENT25:  v = 16'd25;
         CENT50:  v = 16'd50;
         REAL1:   v = 16'd100;
         REAL2:   v = 16'd200;
         REAL5:   v = 16'd500;
         REAL10:  v = 16'd1000;
         default: v = 16'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/coffee_script_mem.sv
// Script storage: one write port, one registered read port that only
// updates when re is high, so the read word stays put between fetches.
module coffee_script_mem #(
   parameter  int DEPTH = 16,
   parameter  int W     = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic [W-1:0] rdata_q, rdata_d;

   // Next array contents and read register
   always_comb begin
      mem_d   = mem_q;
      rdata_d = rdata_q;
      if (we) mem_d[waddr] = wdata;
      if (re) rdata_d = mem_q[raddr];
   end

   // Storage registers (contents are left unreset on purpose)
   always_ff @(posedge clock) begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/coffee_stim_seq.sv
// Scriptable stimulus sequencer: resets the machine, then plays coin and
// selection entries over valid/ack handshakes with timeout and looping.
module coffee_stim_seq #(
   parameter  int COIN_W       = 3,
   parameter  int SEL_W        = 2,
   parameter  int DEPTH        = 16,
   parameter  int RESET_CYCLES = 10,
   parameter  int TIMEOUT      = 64,
   localparam int AW           = $clog2(DEPTH),
   localparam int LW           = AW + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              prog_we,
   input  logic [AW-1:0]     prog_addr,
   input  logic [COIN_W:0]   prog_data,
   input  logic [LW-1:0]     script_len,
   input  logic              loop_mode,
   input  logic              start,
   input  logic              stop,
   output logic              dut_reset,
   output logic [COIN_W-1:0] dinheiro,
   output logic              coin_valid,
   input  logic              coin_ack,
   output logic [SEL_W-1:0]  selec_produto,
   output logic              sel_valid,
   input  logic              sel_ack,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       total_cents
);
   import coffee_pkg::*;

   localparam int CNT_MAX = (RESET_CYCLES > TIMEOUT) ? RESET_CYCLES : TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;     // reset-hold and ack-wait counter
   logic [LW-1:0]     idx_q, idx_d;
   logic [LW-1:0]     len_q, len_d;
   logic              loop_q, loop_d;
   logic [15:0]       total_q, total_d;
   logic              err_q, err_d;
   logic              rd_en;
   logic [COIN_W:0]   ent;
   logic              xfer;
   logic [16:0]       sum;

   coffee_script_mem #(.DEPTH(DEPTH), .W(COIN_W + 1)) u_mem (
      .clock (clock),
      .we    (prog_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .re    (rd_en),
      .raddr (idx_q[AW-1:0]),
      .rdata (ent)
   );

   assign sum = {1'b0, total_q} + {1'b0, coin_value(3'(ent[COIN_W-1:0]))};

   // Next-state, datapath updates and handshake outputs
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      len_d         = len_q;
      loop_d        = loop_q;
      total_d       = total_q;
      err_d         = err_q;
      rd_en         = 1'b0;
      xfer          = 1'b0;
      dut_reset     = 1'b0;
      dinheiro      = '0;
      coin_valid    = 1'b0;
      selec_produto = '0;
      sel_valid     = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            done = (state_q == ST_DONE);
            if (start && !stop) begin
               state_d = ST_RST_DUT;
               cnt_d   = '0;
               idx_d   = '0;
               len_d   = script_len;
               loop_d  = loop_mode;
               total_d = '0;
               err_d   = 1'b0;
            end
         end
         ST_RST_DUT: begin
            busy      = 1'b1;
            dut_reset = 1'b1;
            if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = (len_q == '0) ? ST_DONE : ST_FETCH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_FETCH: begin
            busy    = 1'b1;
            rd_en   = 1'b1;
            cnt_d   = '0;
            state_d = ST_DRIVE;
         end
         ST_DRIVE: begin
            busy = 1'b1;
            if (ent[COIN_W] == KIND_COIN) begin
               coin_valid = 1'b1;
               dinheiro   = ent[COIN_W-1:0];
               xfer       = coin_ack;
            end else begin
               sel_valid     = 1'b1;
               selec_produto = ent[SEL_W-1:0];
               xfer          = sel_ack;
            end
            if (xfer) begin
               state_d = ST_GAP;
               if (ent[COIN_W] == KIND_COIN)
                  total_d = sum[16] ? 16'hFFFF : sum[15:0];
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_GAP: begin
            busy = 1'b1;
            if ((idx_q + 1'b1) == len_q) begin
               if (loop_q) begin
                  idx_d   = '0;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort has priority over everything except the retained total/err
      if (stop && state_q != ST_IDLE) state_d = ST_IDLE;
   end

   // State and datapath registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         loop_q  <= 1'b0;
         total_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         loop_q  <= loop_d;
         total_q <= total_d;
         err_q   <= err_d;
      end
   end

   assign err         = err_q;
   assign total_cents = total_q;

endmodule

// File: tb/tb_coffee_stim_seq.sv
// Bench for coffee_stim_seq: plays directed and random scripts against a
// transfer-level model of what the machine should see.
module tb_coffee_stim_seq;
   localparam int COIN_W = 3, SEL_W = 2, DEPTH = 16, RC = 10, TMO = 64;
   localparam int AW = $clog2(DEPTH);

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              prog_we = 1'b0;
   logic [AW-1:0]     prog_addr = '0;
   logic [COIN_W:0]   prog_data = '0;
   logic [AW:0]       script_len = '0;
   logic              loop_mode = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              coin_ack = 1'b0;
   logic              sel_ack = 1'b0;
   logic              dut_reset, coin_valid, sel_valid, busy, done, err;
   logic [COIN_W-1:0] dinheiro;
   logic [SEL_W-1:0]  selec_produto;
   logic [15:0]       total_cents;

   int checks = 0, errors = 0;
   logic [COIN_W:0] scr [DEPTH];
   int vals [8] = '{5, 10, 25, 50, 100, 200, 500, 1000};
   int d [DEPTH];

   always #5 clock = ~clock;

   coffee_stim_seq #(.COIN_W(COIN_W), .SEL_W(SEL_W), .DEPTH(DEPTH),
                     .RESET_CYCLES(RC), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .script_len(script_len), .loop_mode(loop_mode),
      .start(start), .stop(stop), .dut_reset(dut_reset), .dinheiro(dinheiro),
      .coin_valid(coin_valid), .coin_ack(coin_ack), .selec_produto(selec_produto),
      .sel_valid(sel_valid), .sel_ack(sel_ack), .busy(busy), .done(done),
      .err(err), .total_cents(total_cents)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic prog(input int a, input logic [COIN_W:0] v);
      prog_we = 1'b1; prog_addr = AW'(a); prog_data = v;
      tick();
      prog_we = 1'b0;
      scr[a] = v;
   endtask

   // Expected handshake on the active channel for a script entry
   task automatic chk_drive(input bit ks, input int code);
      if (!ks) begin
         chk("coin_valid", coin_valid, 1);
         chk("sel_quiet", sel_valid, 0);
         chk("dinheiro", dinheiro, code);
      end else begin
         chk("sel_valid", sel_valid, 1);
         chk("coin_quiet", coin_valid, 0);
         chk("selec", selec_produto, code % (1 << SEL_W));
      end
   endtask

   // Play `plays` entries; dly[i] = cycles before ack (>= TMO means never)
   task automatic run(input int len, input bit lp, input int plays, input int dly [DEPTH]);
      int exp_total, n, i, code, w;
      bit exp_err, ks;
      exp_total = 0; exp_err = 0;
      script_len = (AW+1)'(len); loop_mode = lp;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_start", busy, 1);
      n = 0;
      while (dut_reset === 1'b1 && n < 100) begin n++; tick(); end
      chk("rst_cycles", n, RC);
      for (int k = 0; k < plays; k++) begin
         i = k % len;
         chk("fetch_novalid", {coin_valid, sel_valid}, 0);
         chk("fetch_busy", busy, 1);
         tick();
         ks = scr[i][COIN_W];
         code = int'(scr[i][COIN_W-1:0]);
         w = (dly[i] < TMO) ? dly[i] : TMO;
         for (int c = 0; c < w; c++) begin
            chk_drive(ks, code);
            coin_ack = ks; sel_ack = !ks; start = 1'b1;
            if (c == 0) begin
               prog_we = 1'b1; prog_addr = AW'(i); prog_data = ~scr[i];
               scr[i] = ~scr[i];
            end
            tick();
            prog_we = 1'b0;
         end
         start = 1'b0; coin_ack = 1'b0; sel_ack = 1'b0;
         if (dly[i] < TMO) begin
            chk_drive(ks, code);
            coin_ack = !ks; sel_ack = ks;
            tick();
            coin_ack = 1'b0; sel_ack = 1'b0;
            if (!ks) begin
               exp_total += vals[code];
               if (exp_total > 65535) exp_total = 65535;
            end
         end else begin
            exp_err = 1'b1;
         end
         chk("gap_novalid", {coin_valid, sel_valid}, 0);
         chk("gap_total", total_cents, exp_total);
         chk("gap_err", err, exp_err);
         chk("gap_nodone", done, 0);
         tick();
      end
      if (!lp) begin
         chk("done", done, 1);
         chk("done_busy", busy, 0);
         chk("done_total", total_cents, exp_total);
         chk("done_err", err, exp_err);
         chk("done_novalid", {coin_valid, sel_valid, dut_reset}, 0);
         tick(); tick();
         chk("done_held", done, 1);
      end else begin
         chk("loop_nodone", done, 0);
         tick();
         chk("loop_drive", coin_valid | sel_valid, 1);
         stop = 1'b1; start = 1'b1;
         tick();
         stop = 1'b0; start = 1'b0;
         chk("stop_busy", busy, 0);
         chk("stop_novalid", {coin_valid, sel_valid, dut_reset}, 0);
         chk("stop_done", done, 0);
         chk("stop_total", total_cents, exp_total);
         chk("stop_err", err, exp_err);
      end
   endtask

   initial begin
      // Reset values
      tick(); tick();
      chk("rst_outs", {dut_reset, coin_valid, sel_valid, busy, done, err}, 0);
      chk("rst_total", total_cents, 0);
      reset = 1'b1;
      tick();
      chk("idle_busy", busy, 0);

      // Coin REAL10 then CAFE, immediate acks
      prog(0, {1'b0, 3'd7});
      prog(1, {1'b1, 3'd0});
      d = '{default: 0};
      run(2, 1'b0, 2, d);

      // Coins 3,3,4 with 5-cycle ack delay
      prog(0, {1'b0, 3'd3}); prog(1, {1'b0, 3'd3}); prog(2, {1'b0, 3'd4});
      d = '{default: 5};
      run(3, 1'b0, 3, d);

      // Coin with no ack: timeout
      prog(0, {1'b0, 3'd2});
      d = '{default: 200};
      run(1, 1'b0, 1, d);

      // Empty script
      d = '{default: 0};
      run(0, 1'b0, 0, d);

      // Looping REAL10 until saturation, then stop
      prog(0, {1'b0, 3'd7});
      run(1, 1'b1, 70, d);

      // start and stop together while idle
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("startstop_idle", busy, 0);

      // Reset asserted during DRIVE
      prog(0, {1'b0, 3'd2});
      script_len = 1; loop_mode = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (RC + 1) tick();
      chk("pre_rst_valid", coin_valid, 1);
      reset = 1'b0;
      tick();
      chk("midrst_outs", {dut_reset, coin_valid, sel_valid, busy, done, err}, 0);
      chk("midrst_total", total_cents, 0);
      reset = 1'b1;
      tick();
      chk("midrst_idle", busy, 0);

      // Random scripts and ack delays
      for (int r = 0; r < 6; r++) begin
         int len;
         len = int'($urandom_range(1, 6));
         for (int i = 0; i < len; i++) begin
            prog(i, {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))});
            d[i] = ($urandom_range(0, 4) == 0) ? 100 : int'($urandom_range(0, 6));
         end
         run(len, 1'b0, len, d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
